// File: rtl/rom_pkg.sv
// Shared constants and types for the small synchronous lookup ROM.
//
// Contents:
//   ROM_DATA_W / ROM_ADDR_W / ROM_DEPTH : default geometry (4 words x 4 bits)
//   ROM_INIT_DEFAULT                    : default packed contents, word 0 in the LSBs
//   rom_word_t / rom_addr_t             : word and address types at default geometry
package rom_pkg;

  localparam int unsigned ROM_DATA_W = 4;
  localparam int unsigned ROM_ADDR_W = 2;
  localparam int unsigned ROM_DEPTH  = 2 ** ROM_ADDR_W;

  // Word k lives at bits [k*ROM_DATA_W +: ROM_DATA_W]:
  //   addr 0 = 0011, addr 1 = 0101, addr 2 = 1010, addr 3 = 1100
  localparam logic [ROM_DEPTH*ROM_DATA_W-1:0] ROM_INIT_DEFAULT =
    {4'b1100, 4'b1010, 4'b0101, 4'b0011};

  typedef logic [ROM_DATA_W-1:0] rom_word_t;
  typedef logic [ROM_ADDR_W-1:0] rom_addr_t;

endpackage : rom_pkg

// File: rtl/rom_4x4_sync.sv
// Synchronous read-only memory with one-cycle registered read.
//
// The contents are fixed at elaboration from ROM_INIT and never change.
// The address is sampled on each rising clock edge, and the addressed word
// is registered onto data_out. An asynchronous active-low reset clears the
// output register immediately.
//
// Ports:
//   clk      : system clock, rising-edge active
//   rst_n    : asynchronous active-low reset; clears data_out to zero
//   address  : read address, sampled on the rising edge
//   data_out : registered read data, valid one clock after the address
module rom_4x4_sync
  import rom_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ROM_DATA_W,
  parameter int unsigned ADDR_WIDTH = ROM_ADDR_W,
  parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] ROM_INIT = ROM_INIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Constant word array unpacked from the packed initialiser.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_unpack
    assign mem[k] = ROM_INIT[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Every address value maps to a valid word, so no range check is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else begin
      data_out <= mem[address];
    end
  end

endmodule : rom_4x4_sync

// File: tb/tb_rom_4x4_sync.sv
// Self-checking bench for rom_4x4_sync: a default-contents instance and an
// instance with overridden contents share clock, reset and address.
module tb_rom_4x4_sync;
  import rom_pkg::*;

  logic      clk;
  logic      rst_n;
  rom_addr_t address;
  rom_word_t data_def;
  rom_word_t data_ovr;

  int unsigned total;
  int unsigned bad;

  rom_4x4_sync #(
    .DATA_WIDTH(4),
    .ADDR_WIDTH(2)
  ) dut_def (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .data_out (data_def)
  );

  rom_4x4_sync #(
    .DATA_WIDTH(4),
    .ADDR_WIDTH(2),
    .ROM_INIT  ({4'hF, 4'h0, 4'h9, 4'h6})
  ) dut_ovr (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .data_out (data_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference contents written out independently of the RTL.
  rom_word_t ref_def [4];
  rom_word_t ref_ovr [4];

  typedef struct {
    string     name;
    rom_word_t e_def;
    rom_word_t e_ovr;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    rom_addr_t addr;
    rom_word_t e_def;
    rom_word_t e_ovr;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input rom_word_t act, input rom_word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive an address (away from the edge), queue its expected result,
  // then let one edge pass and compare against the queue head.
  task automatic read_step(input string name, input rom_addr_t a,
                           input rom_word_t e_def, input rom_word_t e_ovr);
    sb_t s;
    address = a;
    sb.push_back('{name, e_def, e_ovr});
    @(posedge clk);
    #2;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got %b", name, data_def);
    end else begin
      s = sb.pop_front();
      check({s.name, "_def"}, data_def, s.e_def);
      check({s.name, "_ovr"}, data_ovr, s.e_ovr);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ref_def = '{4'b0011, 4'b0101, 4'b1010, 4'b1100};
    ref_ovr = '{4'h6, 4'h9, 4'h0, 4'hF};

    // Sweep 0..3, then the 3,0,0,2,1 wrap sequence.
    vecs[0] = '{2'd0, 4'b0011, 4'h6};
    vecs[1] = '{2'd1, 4'b0101, 4'h9};
    vecs[2] = '{2'd2, 4'b1010, 4'h0};
    vecs[3] = '{2'd3, 4'b1100, 4'hF};
    vecs[4] = '{2'd3, 4'b1100, 4'hF};
    vecs[5] = '{2'd0, 4'b0011, 4'h6};
    vecs[6] = '{2'd0, 4'b0011, 4'h6};
    vecs[7] = '{2'd2, 4'b1010, 4'h0};
    vecs[8] = '{2'd1, 4'b0101, 4'h9};

    // Reset held for 3 clocks with address 2.
    rst_n   = 1'b0;
    address = 2'd2;
    #1;
    check("reset_immediate_def", data_def, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check("reset_hold_def", data_def, 4'b0000);
      check("reset_hold_ovr", data_ovr, 4'h0);
    end
    rst_n = 1'b1;
    read_step("first_after_reset", 2'd2, 4'b1010, 4'h0);

    // Table-driven sweep and wrap sequence.
    for (int i = 0; i < 9; i++) begin
      read_step($sformatf("vec%0d", i), vecs[i].addr, vecs[i].e_def, vecs[i].e_ovr);
    end

    // Latency: address 1 -> 3 changed just after an edge.
    read_step("lat_addr1", 2'd1, 4'b0101, 4'h9);
    address = 2'd3;
    #3;
    check("lat_hold_def", data_def, 4'b0101);
    check("lat_hold_ovr", data_ovr, 4'h9);
    @(posedge clk);
    #2;
    check("lat_update_def", data_def, 4'b1100);
    check("lat_update_ovr", data_ovr, 4'hF);

    // Async reset mid-read, between edges.
    check("pre_async_def", data_def, 4'b1100);
    rst_n = 1'b0;
    #1;
    check("async_clear_def", data_def, 4'b0000);
    check("async_clear_ovr", data_ovr, 4'h0);
    @(posedge clk);
    #2;
    check("async_hold_def", data_def, 4'b0000);
    rst_n = 1'b1;
    read_step("post_async", 2'd3, 4'b1100, 4'hF);

    // Random reads against the reference arrays.
    for (int i = 0; i < 24; i++) begin
      rom_addr_t a;
      a = rom_addr_t'($urandom_range(0, 3));
      read_step($sformatf("rand%0d", i), a, ref_def[a], ref_ovr[a]);
    end

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench never hangs.
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_rom_4x4_sync

// File: doc/rom_4x4_sync.md
Name: rom_4x4_sync

Overview:
- Synchronous read-only memory: 4 words x 4 bits, with contents fixed at elaboration.
- The address is sampled on the rising clock edge, and the addressed word appears on a registered output.
- Used as a small lookup table or constant store wherever a one-cycle-latency table read is acceptable.

Parameters:
- DATA_WIDTH, 4: bits per word.
- ADDR_WIDTH, 2: address bits; depth = 2**ADDR_WIDTH = 4 words.
- ROM_INIT, {4'b1100, 4'b1010, 4'b0101, 4'b0011}: packed contents, DEPTH*DATA_WIDTH bits. Word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH], so word 0 is in the LSBs.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- address  input  ADDR_WIDTH  read address.
- data_out  output  DATA_WIDTH  registered read data.

Interface (already decided):
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Storage:
  - Constant array of 4 words, built from ROM_INIT.
  - Default contents: addr 0 = 4'b0011, addr 1 = 4'b0101, addr 2 = 4'b1010, addr 3 = 4'b1100.
  - No write path exists; the contents never change at runtime.
- Read:
  - On each rising edge of clk with rst_n high, data_out <= mem[address].
  - Latency is exactly one clock: an address applied before edge N is visible on data_out after edge N and holds until edge N+1.
- Output stability:
  - data_out changes only on a rising clk edge or on reset assertion.
  - Address changes between edges have no effect until the next edge.
- Reset:
  - rst_n low forces data_out to 4'b0000 immediately, without waiting for a clock edge.
  - data_out holds 0 while rst_n stays low.
  - Reset mid-operation discards the in-flight read.
  - The first rising edge with rst_n high loads mem[address].
- Deassertion: rst_n is released synchronously to clk by the system. No read occurs on an edge where rst_n is low.
- Addressing:
  - All 2**ADDR_WIDTH addresses are valid, so no out-of-range case exists.
  - Consecutive addresses 3 -> 0 need no special handling; any address sequence, including repeats, is legal every cycle.
- X handling: if address contains X/Z at a sampling edge, data_out becomes X in simulation only. Synthesis behaviour is unconstrained; the bench must not rely on it.
- Synthesis:
  - Infers a small ROM/LUT followed by a DATA_WIDTH-bit register with async clear.
  - No latches, no combinational path from address to data_out.

Decomposition:
- Shared package rom_pkg holds:
  - ROM_DATA_W = 4
  - ROM_ADDR_W = 2
  - ROM_DEPTH = 4
  - the default ROM_INIT constant
  - typedefs rom_word_t (logic [3:0]) and rom_addr_t (logic [1:0])
- Single flat module; no sub-module is warranted.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with address=2 -> data_out=4'b0000 throughout. Release rst_n; after the first edge data_out=4'b1010.
- Sequential sweep: apply address 0,1,2,3, one per 10 ns clock period, sampling mid-period after each edge -> data_out = 0011, 0101, 1010, 1100.
- Latency: change address from 1 to 3 just after an edge -> data_out stays 0101 until the next edge, then becomes 1100. The value must never change between edges.
- Async reset mid-read: with address=3 and data_out=1100, drop rst_n between edges -> data_out=0000 immediately, before the next edge.
- Random order with wrap: sequence 3,0,0,2,1 on consecutive cycles -> data_out = 1100, 0011, 0011, 1010, 0101, each one cycle after its address.
- Parameter override: instantiate with ROM_INIT={4'hF,4'h0,4'h9,4'h6} and read addresses 0..3 -> 6, 9, 0, F.
